// File: rtl/led_group_sequencer.sv
// led_group_sequencer: UART-framed config of four LED groups, sequenced one at a time with 100-step PWM.
// Optional LED_SEQ_DONE_REPORT_EN queues byte 0xD0 when a finite run completes on its own.
module led_group_sequencer #(
  parameter int PWM_DIV  = 500,
  parameter int TICK_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic [7:0] txdata,
  output logic       tx_DataEn,
  input  logic       tx_done,
  output logic [3:0] led_out,
  output logic       busy,
  output logic [1:0] cur_group
);
  localparam int PW = $clog2(PWM_DIV + 1);
  localparam int TW = $clog2(TICK_DIV + 1);
  typedef enum logic [1:0] {P_HDR, P_CMD, P_VAL} p_t;
  typedef enum logic [1:0] {T_IDLE, T_SEND, T_WAIT} t_t;
  typedef enum logic {S_IDLE, S_RUN} s_t;
  p_t p_q, p_d;
  t_t t_q, t_d;
  s_t s_q, s_d;
  logic [7:0] cmd_q, cmd_d, val_q, val_d;
  logic exec_q, exec_d, start_q, start_d, stop_q, stop_d;
  logic [3:0][6:0] duty_q, duty_d;
  logic [3:0][7:0] dwell_q, dwell_d;
  logic [7:0] rounds_q, rounds_d, rcnt_q, rcnt_d, dcnt_q, dcnt_d;
  logic [1:0] grp_q, grp_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [6:0] step_q, step_d, shadow_q, shadow_d;
  logic pend_q, pend_d;
  logic [7:0] pbyte_q, pbyte_d, txdata_q, txdata_d;
  logic ok, done_ev, enter, step_en, tick, expire, resp_v, pv;
  logic [7:0] resp, pb;
  assign p_d = !rx_done ? p_q :
               p_q == P_HDR ? (rx_data == 8'hA5 ? P_CMD : P_HDR) :
               p_q == P_CMD ? (rx_data == 8'hA5 ? P_CMD : P_VAL) : P_HDR;
  assign cmd_d  = rx_done && p_q == P_CMD ? rx_data : cmd_q;
  assign val_d  = rx_done && p_q == P_VAL ? rx_data : val_q;
  assign exec_d = rx_done && p_q == P_VAL;
  always_comb begin
    duty_d = duty_q;
    dwell_d = dwell_q;
    rounds_d = rounds_q;
    ok = 1'b0;
    start_d = 1'b0;
    stop_d = 1'b0;
    if (exec_q) begin
      if (cmd_q[7:2] == 6'b000100) begin
        duty_d[cmd_q[1:0]] = val_q > 8'd100 ? 7'd100 : val_q[6:0];
        ok = 1'b1;
      end else if (cmd_q[7:2] == 6'b001000) begin
        dwell_d[cmd_q[1:0]] = val_q == 8'd0 ? 8'd1 : val_q;
        ok = 1'b1;
      end else if (cmd_q == 8'h30) begin
        rounds_d = val_q;
        start_d = 1'b1;
        ok = 1'b1;
      end else if (cmd_q == 8'h40) begin
        stop_d = 1'b1;
        ok = 1'b1;
      end
    end
  end
  assign step_en = pcnt_q == PW'(PWM_DIV - 1);
  assign pcnt_d  = step_en ? '0 : pcnt_q + 1'b1;
  assign step_d  = !step_en ? step_q : step_q == 7'd99 ? 7'd0 : step_q + 7'd1;
  assign tick    = tcnt_q == TW'(TICK_DIV - 1);
  assign tcnt_d  = tick ? '0 : tcnt_q + 1'b1;
  assign expire  = s_q == S_RUN && tick && dcnt_q + 8'd1 >= dwell_q[grp_q];
  // start/stop commands take priority over a coincident dwell expiry
  always_comb begin
    s_d = s_q;
    grp_d = grp_q;
    dcnt_d = dcnt_q;
    rcnt_d = rcnt_q;
    enter = 1'b0;
    done_ev = 1'b0;
    if (start_q) begin
      s_d = S_RUN;
      grp_d = 2'd0;
      dcnt_d = 8'd0;
      rcnt_d = 8'd0;
      enter = 1'b1;
    end else if (stop_q) begin
      s_d = S_IDLE;
    end else if (expire) begin
      dcnt_d = 8'd0;
      if (grp_q == 2'd3) begin
        rcnt_d = rcnt_q + 8'd1;
        if (rounds_q != 8'd0 && rcnt_d == rounds_q) begin
          s_d = S_IDLE;
`ifdef LED_SEQ_DONE_REPORT_EN
          done_ev = 1'b1;
`endif
        end else begin
          grp_d = 2'd0;
          enter = 1'b1;
        end
      end else begin
        grp_d = grp_q + 2'd1;
        enter = 1'b1;
      end
    end else if (s_q == S_RUN && tick) begin
      dcnt_d = dcnt_q + 8'd1;
    end
  end
  assign shadow_d = enter ? duty_q[grp_d] : step_en && step_q == 7'd99 ? duty_q[grp_q] : shadow_q;
  // a fresh response bypasses the pending slot when the transmitter is idle
  assign resp_v   = exec_q | done_ev;
  assign resp     = exec_q ? (ok ? 8'h5A : 8'hEE) : 8'hD0;
  assign pv       = pend_q | resp_v;
  assign pb       = resp_v ? resp : pbyte_q;
  assign t_d      = t_q == T_IDLE ? (pv ? T_SEND : T_IDLE) : t_q == T_SEND ? T_WAIT : (tx_done ? T_IDLE : T_WAIT);
  assign txdata_d = t_q == T_IDLE && pv ? pb : txdata_q;
  assign pend_d   = pv && t_q != T_IDLE;
  assign pbyte_d  = pb;
  always_ff @(posedge clk) begin
    if (rst) begin
      p_q <= P_HDR;
      t_q <= T_IDLE;
      s_q <= S_IDLE;
      cmd_q <= 8'd0;
      val_q <= 8'd0;
      exec_q <= 1'b0;
      start_q <= 1'b0;
      stop_q <= 1'b0;
      duty_q <= {4{7'd50}};
      dwell_q <= {4{8'd100}};
      rounds_q <= 8'd0;
      rcnt_q <= 8'd0;
      dcnt_q <= 8'd0;
      grp_q <= 2'd0;
      pcnt_q <= '0;
      tcnt_q <= '0;
      step_q <= 7'd0;
      shadow_q <= 7'd0;
      pend_q <= 1'b0;
      pbyte_q <= 8'd0;
      txdata_q <= 8'd0;
    end else begin
      p_q <= p_d;
      t_q <= t_d;
      s_q <= s_d;
      cmd_q <= cmd_d;
      val_q <= val_d;
      exec_q <= exec_d;
      start_q <= start_d;
      stop_q <= stop_d;
      duty_q <= duty_d;
      dwell_q <= dwell_d;
      rounds_q <= rounds_d;
      rcnt_q <= rcnt_d;
      dcnt_q <= dcnt_d;
      grp_q <= grp_d;
      pcnt_q <= pcnt_d;
      tcnt_q <= tcnt_d;
      step_q <= step_d;
      shadow_q <= shadow_d;
      pend_q <= pend_d;
      pbyte_q <= pbyte_d;
      txdata_q <= txdata_d;
    end
  end
  assign txdata    = txdata_q;
  assign tx_DataEn = t_q == T_SEND;
  assign busy      = s_q == S_RUN;
  assign cur_group = grp_q;
  assign led_out   = busy && step_q < shadow_q ? 4'b0001 << grp_q : 4'b0000;
endmodule

// File: tb/tb_led_group_sequencer.sv
// tb_led_group_sequencer: command vectors, sequencing runs, PWM duty and tx handshake corner cases.
module tb_led_group_sequencer;
  logic clk = 0, rst, rx_done, tx_done, tx_DataEn, busy;
  logic [7:0] rx_data, txdata;
  logic [3:0] led_out;
  logic [1:0] cur_group;
  int errs = 0, checks = 0, tx_cnt = 0;
  bit hold_done = 0, owe = 0;
  logic [7:0] exp_q[$];
  typedef struct { logic [7:0] pre, cmd, val, rsp; } vec_t;
  vec_t v[13];

  led_group_sequencer #(.PWM_DIV(2), .TICK_DIV(20)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done), .txdata(txdata),
    .tx_DataEn(tx_DataEn), .tx_done(tx_done), .led_out(led_out), .busy(busy), .cur_group(cur_group)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (tx_DataEn) begin
    tx_cnt++;
    if (exp_q.size() == 0) begin
      errs++;
      checks++;
      $display("FAIL tx_unexpected: got %02h with nothing expected", txdata);
    end else check("tx_byte", txdata, exp_q.pop_front());
  end

  initial begin
    tx_done = 0;
    forever begin
      @(negedge clk);
      if (tx_DataEn) owe = 1;
      if (owe && !hold_done) begin
        repeat (3) @(negedge clk);
        tx_done = 1;
        @(negedge clk);
        tx_done = 0;
        owe = 0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1;
    @(negedge clk);
    rx_done = 0;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] val);
    send_byte(8'hA5);
    send_byte(c);
    send_byte(val);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      errs++;
      checks++;
      $display("FAIL tx_timeout: %0d bytes still expected", exp_q.size());
      exp_q.delete();
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic measure_g1(input string name, input int exp_hi);
    int hi = 0;
    bit found = 0;
    logic prev = led_out[0];
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      found = !prev && led_out[0];
      prev = led_out[0];
    end
    if (!found) begin
      errs++;
      checks++;
      $display("FAIL %s_edge: no rising edge on G1 within 400 cycles", name);
    end else begin
      for (int i = 0; i < 200; i++) begin
        hi += int'(led_out[0]);
        @(negedge clk);
      end
      check(name, hi, exp_hi);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_txdata"}, txdata, 8'h00);
    check({tag, "_txen"}, tx_DataEn, 0);
    check({tag, "_led"}, led_out, 4'h0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_grp"}, cur_group, 2'd0);
  endtask

  initial begin
    logic [15:0] seq;
    logic [1:0] last, g;
    int nseq, other, g2hi, g4lo, g4n, wraps, drops, base;
    v[0]  = '{8'h33, 8'h12, 8'h19, 8'h5A};
    v[1]  = '{8'hA5, 8'h10, 8'hC8, 8'h5A};
    v[2]  = '{8'h00, 8'h55, 8'h00, 8'hEE};
    v[3]  = '{8'hA5, 8'h14, 8'h10, 8'hEE};
    v[4]  = '{8'h77, 8'h24, 8'h05, 8'hEE};
    v[5]  = '{8'h00, 8'h31, 8'h02, 8'hEE};
    v[6]  = '{8'hA5, 8'h11, 8'h00, 8'h5A};
    v[7]  = '{8'h01, 8'h13, 8'h64, 8'h5A};
    v[8]  = '{8'h00, 8'h20, 8'h01, 8'h5A};
    v[9]  = '{8'h00, 8'h21, 8'h01, 8'h5A};
    v[10] = '{8'h00, 8'h22, 8'h01, 8'h5A};
    v[11] = '{8'hA5, 8'h23, 8'h00, 8'h5A};
    v[12] = '{8'h00, 8'h10, 8'h1E, 8'h5A};
    rst = 1;
    rx_data = 0;
    rx_done = 0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 0;
    for (int i = 0; i < 13; i++) begin
      exp_q.push_back(v[i].rsp);
      send_byte(v[i].pre);
      send_frame(v[i].cmd, v[i].val);
      check($sformatf("vec%0d_txen_c1", i), tx_DataEn, 0);
      @(negedge clk);
      check($sformatf("vec%0d_txen_c2", i), tx_DataEn, 1);
      wait_drain();
      check($sformatf("vec%0d_busy", i), busy, 0);
      check($sformatf("vec%0d_led", i), led_out, 4'h0);
    end
    // two rounds, duty = {30,0,25,100}, dwell all 1
    exp_q.push_back(8'h5A);
`ifdef LED_SEQ_DONE_REPORT_EN
    exp_q.push_back(8'hD0);
`endif
    send_frame(8'h30, 8'h02);
    @(negedge clk);
    check("start_busy_lag", busy, 0);
    @(negedge clk);
    check("start_busy", busy, 1);
    check("start_grp", cur_group, 2'd0);
    seq = 0; nseq = 1; last = 0; other = 0; g2hi = 0; g4lo = 0; g4n = 0;
    for (int i = 0; i < 2000 && busy; i++) begin
      if (cur_group != last) begin
        seq = {seq[13:0], cur_group};
        nseq++;
        last = cur_group;
      end
      if ((led_out & ~(4'b0001 << cur_group)) != 0) other++;
      if (cur_group == 2'd1 && led_out[1]) g2hi++;
      if (cur_group == 2'd3) begin
        g4n++;
        if (!led_out[3]) g4lo++;
      end
      @(negedge clk);
    end
    check("run2_busy_end", busy, 0);
    check("run2_led_end", led_out, 4'h0);
    check("run2_nseq", nseq, 8);
    check("run2_seq", seq, 16'h1B1B);
    check("run2_other_bits", other, 0);
    check("run2_g2_duty0", g2hi, 0);
    check("run2_g4_seen", g4n > 0, 1);
    check("run2_g4_duty100", g4lo, 0);
    wait_drain();
    // long G1 dwell to measure a full PWM period at duty 30
    exp_q.push_back(8'h5A);
    send_frame(8'h20, 8'h28);
    wait_drain();
    exp_q.push_back(8'h5A);
`ifdef LED_SEQ_DONE_REPORT_EN
    exp_q.push_back(8'hD0);
`endif
    send_frame(8'h30, 8'h01);
    measure_g1("g1_duty30", 60);
    for (int i = 0; i < 2000 && busy; i++) @(negedge clk);
    check("run1_busy_end", busy, 0);
    wait_drain();
    // continuous run, stop after three wraps
    exp_q.push_back(8'h5A);
    send_frame(8'h30, 8'h00);
    @(negedge clk);
    @(negedge clk);
    wraps = 0; drops = 0; last = cur_group;
    for (int i = 0; i < 6000 && wraps < 3; i++) begin
      @(negedge clk);
      if (last == 2'd3 && cur_group == 2'd0) wraps++;
      if (!busy) drops++;
      last = cur_group;
    end
    check("cont_wraps", wraps, 3);
    check("cont_no_drop", drops, 0);
    exp_q.push_back(8'h5A);
    send_frame(8'h40, 8'h00);
    @(negedge clk);
    check("stop_busy_lag", busy, 1);
    g = cur_group;
    @(negedge clk);
    check("stop_busy", busy, 0);
    check("stop_led", led_out, 4'h0);
    check("stop_grp_hold", cur_group, g);
    wait_drain();
    repeat (200) @(negedge clk);
    // tx_done held low: second ACK overwritten by NAK
    hold_done = 1;
    base = tx_cnt;
    exp_q.push_back(8'h5A);
    send_frame(8'h22, 8'h01);
    send_frame(8'h23, 8'h01);
    exp_q.push_back(8'hEE);
    send_frame(8'h66, 8'h00);
    repeat (30) @(negedge clk);
    check("hold_one_sent", tx_cnt - base, 1);
    hold_done = 0;
    wait_drain();
    repeat (30) @(negedge clk);
    check("hold_two_sent", tx_cnt - base, 2);
    // reset mid-run
    exp_q.push_back(8'h5A);
    send_frame(8'h30, 8'h00);
    wait_drain();
    repeat (50) @(negedge clk);
    check("prerst_busy", busy, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check_reset_outputs("rst_run");
    // reset between bytes 2 and 3, then a lone value byte
    send_byte(8'hA5);
    send_byte(8'h12);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check_reset_outputs("rst_frame");
    base = tx_cnt;
    send_byte(8'h07);
    repeat (20) @(negedge clk);
    check("lone_val_no_tx", tx_cnt - base, 0);
    check("lone_val_busy", busy, 0);
    // reset duty (50) and dwell (100) restored
    exp_q.push_back(8'h5A);
    send_frame(8'h30, 8'h00);
    measure_g1("g1_duty_reset50", 100);
    check("reset_dwell_still_g1", cur_group, 2'd0);
    exp_q.push_back(8'h5A);
    send_frame(8'h40, 8'h00);
    wait_drain();
    check("final_busy", busy, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/led_group_sequencer.md
# led_group_sequencer

UART-commanded controller for the four polarization LED groups (G1–G4). It parses 3-byte command frames from the UART receiver into per-group duty and dwell registers. It then sequences the groups one at a time, driving the active group with a 100-step PWM. Every frame is acknowledged through the UART transmitter handshake.

## Interface
- `PWM_DIV`, default 500: clk cycles per PWM step; 100 steps per period, giving a 1 kHz PWM at 50 MHz.
- `TICK_DIV`, default 50000: clk cycles per dwell tick (1 ms).
- `clk`  in  1  50 MHz main clock.
- `rst`  in  1  reset; synchronous, active-high.
- `rx_data`  in  8  received byte; valid when `rx_done`=1.
- `rx_done`  in  1  one-cycle pulse: byte received.
- `txdata`  out  8  byte to transmit.
- `tx_DataEn`  out  1  one-cycle pulse: start transmitting `txdata`.
- `tx_done`  in  1  one-cycle pulse: transmitter finished the current byte.
- `led_out`  out  4  LED group drives; bit0 = G1 … bit3 = G4.
- `busy`  out  1  high while the sequence is running.
- `cur_group`  out  2  active group index; 0 = G1.

## Operation
- **Reset state**
  - Outputs: `txdata`=0x00, `tx_DataEn`=0, `led_out`=0, `busy`=0, `cur_group`=0.
  - Registers: duty[0..3]=50, dwell[0..3]=100, rounds=0, parser in P_HDR, tx FSM in T_IDLE, no response pending.
- **Frame format:** `0xA5`, CMD, VAL.
  - Parser states: P_HDR → P_CMD → P_VAL → P_HDR. Each state advances only on `rx_done`.
  - In P_HDR, non-0xA5 bytes are discarded without a response.
  - A 0xA5 received in P_CMD is taken as a new header; the parser stays in P_CMD.
- **Commands**
  - CMD `0x1g` (g=0..3): duty[g] = min(VAL,100).
  - CMD `0x2g`: dwell[g] = VAL in ms; VAL=0 is stored as 1.
  - CMD `0x30`: start. rounds = VAL; 0 means run continuously.
  - CMD `0x40`: stop.
  - Any other CMD (including g>3): no register change; NAK.
- **Responses:** 0x5A (ACK) for a valid command, 0xEE (NAK) otherwise.
- **Sequencer FSM:** S_IDLE, S_RUN.
  - Start moves to S_RUN at G1 with the dwell counter cleared.
  - In S_RUN the active group is held for dwell[g] ticks, then advances G1→G2→G3→G4.
  - After G4 the round counter increments. If rounds≠0 and the count equals rounds, go to S_IDLE; otherwise wrap to G1.
  - Start received while already running restarts at G1 with the new round count.
  - Stop returns to S_IDLE from any state.
- **PWM**
  - Step counter 0..99, advanced every `PWM_DIV` clks, free-running from reset.
  - Active bit of `led_out` = (step < duty_shadow[g]); all other bits 0. In S_IDLE all bits are 0.
  - duty_shadow loads from duty[] when step wraps to 0 and on group entry. Duty writes while running therefore take effect at the next period boundary, never mid-period.
  - Duty 0 gives constant 0; duty 100 gives constant 1.
- **Tx path:** FSM T_IDLE → T_SEND → T_WAIT.
  - Responses enter a one-deep pending register; a newer response overwrites an unsent older one.
  - T_IDLE with a response pending: load `txdata`, pulse `tx_DataEn` for one cycle, enter T_WAIT.
  - T_WAIT returns to T_IDLE on `tx_done`.

## Timing
- Config register update: the clk edge after the edge sampling the final `rx_done`.
- Response latency: `tx_DataEn` is high in the 2nd cycle after the final-byte `rx_done` cycle, provided the tx FSM is idle. `txdata` holds its value until the next load.
- Start: `busy`=1 and `cur_group`=0 one cycle after the command register update. `led_out` follows the PWM from that cycle.
- Stop: `busy`=0 and `led_out`=0 one cycle after the update. `cur_group` holds its last value.
- Group advance occurs on the tick edge that completes dwell[g]. Dwell is measured from group entry (±1 tick).
- Simultaneous events:
  - A start/stop update in the same cycle as a dwell expiry: the command wins.
  - `rx_done` arriving in the same cycle as `tx_done`: both are handled.
- `rst` mid-frame or mid-run returns all state to reset values on the next edge. An in-flight transmit is abandoned.

## Configuration
- `LED_SEQ_DONE_REPORT_EN`
  - Defined: when a finite run (rounds≠0) completes naturally, byte 0xD0 is queued in the pending register. This follows the same overwrite rule. A stop command does not generate 0xD0.
  - Undefined: no unsolicited transmission; only ACK/NAK bytes are sent.

## Test plan
- Reset, then send A5 12 19 → duty[2]=25; `tx_DataEn` pulses with `txdata`=0x5A; `led_out` stays 0.
- Send A5 10 C8 then A5 55 00 → duty[0]=100 (clamped) and ACK; the second frame gets NAK 0xEE with no register change.
- With `PWM_DIV`=2 and `TICK_DIV`=20, set dwell all=1 and duty[0]=30, then start with rounds=2:
  - G1 output high for 30 of every 100 steps.
  - Groups cycle 0→1→2→3 twice, then `busy`=0 and `led_out`=0.
  - With the macro defined, 0xD0 is transmitted after the ACK.
- Start with rounds=0, wait past 3 rounds, send A5 40 00 → `busy` drops 1 cycle after the update; no 0xD0.
- Hold `tx_done` low and send two valid frames plus a bad one → only the first ACK is transmitted now. After `tx_done`, exactly one further byte, 0xEE, is sent.
- Assert `rst` mid-run and between bytes 2 and 3 of a frame → all outputs return to reset values. A following lone VAL byte is discarded.
